smb_bidir_bypass_ch: RTL



---
 rtl/smb_bidir_bypass_ch.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/smb_bidir_bypass_ch.sv
// N_CH independent open-drain bypass channels between side A and side B.
// Each channel has a synchroniser, a glitch filter, an ownership FSM, a hold-off and a stuck-low timeout.
module smb_bidir_bypass_ch #(
  parameter int N_CH        = 4,
  parameter int FILTER_LEN  = 3,
  parameter int HOLDOFF_CYC = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic            iClk,
  input  logic            iRst_n,
  input  logic [N_CH-1:0] iEnable,
  input  logic [N_CH-1:0] iA_in,
  input  logic [N_CH-1:0] iB_in,
  output logic [N_CH-1:0] oA_drive_low,
  output logic [N_CH-1:0] oB_drive_low,
  input  logic [N_CH-1:0] iClrStuck,
  output logic [N_CH-1:0] oStuck,
  output logic [N_CH-1:0] oBusy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]    F_LEN  = 4'(FILTER_LEN);
  localparam logic [7:0]    H_LEN  = 8'(HOLDOFF_CYC);

  typedef enum logic [2:0] {IDLE, A_OWNS, B_OWNS, HOLDOFF, STUCK} state_t;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v == T_MAX) ? v : v + 1'b1;
  endfunction

  // Returns {next filtered level, next run counter}.
  function automatic logic [4:0] filt_step(input logic sync, input logic filt,
                                           input logic [3:0] cnt);
    logic [3:0] inc;
    inc = cnt + 4'd1;
    if (sync == filt)      return {filt, 4'd0};
    else if (inc == F_LEN) return {sync, 4'd0};
    else                   return {filt, inc};
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]    sync_a, sync_b;
    logic          filt_a, filt_b;
    logic [3:0]    fcnt_a, fcnt_b;
    logic [4:0]    fstep_a, fstep_b;
    state_t        state, state_nx;
    logic          a_drv, b_drv, a_drv_nx, b_drv_nx;
    logic          busy, stuck, stuck_nx, stuck_set;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic [7:0]    hcnt, hcnt_nx;

    assign fstep_a = filt_step(sync_a[1], filt_a, fcnt_a);
    assign fstep_b = filt_step(sync_b[1], filt_b, fcnt_b);

    // Stage p0/p1: two-flop synchroniser; filtered level follows after FILTER_LEN stable cycles
    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        sync_a <= 2'b11;
        sync_b <= 2'b11;
        filt_a <= 1'b1;
        filt_b <= 1'b1;
        fcnt_a <= 4'd0;
        fcnt_b <= 4'd0;
      end else begin
        sync_a <= {sync_a[0], iA_in[i]};
        sync_b <= {sync_b[0], iB_in[i]};
        {filt_a, fcnt_a} <= fstep_a;
        {filt_b, fcnt_b} <= fstep_b;
      end
    end

    always_comb begin
      state_nx  = state;
      a_drv_nx  = 1'b0;
      b_drv_nx  = 1'b0;
      tcnt_nx   = tcnt;
      hcnt_nx   = hcnt;
      stuck_set = 1'b0;
      if (!iEnable[i]) begin
        state_nx = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (!filt_a) begin
              state_nx = A_OWNS;
              b_drv_nx = 1'b1;
              tcnt_nx  = '0;
            end else if (!filt_b) begin
              state_nx = B_OWNS;
              a_drv_nx = 1'b1;
              tcnt_nx  = '0;
            end
          end
          // The far side only echoes our own drive while we own the bus, so it is ignored.
          A_OWNS: begin
            tcnt_nx = sat_inc(tcnt);
            if (filt_a) begin
              state_nx = HOLDOFF;
              hcnt_nx  = H_LEN;
            end else if (tcnt >= T_LAST) begin
              state_nx  = STUCK;
              stuck_set = 1'b1;
            end else begin
              b_drv_nx = 1'b1;
            end
          end
          B_OWNS: begin
            tcnt_nx = sat_inc(tcnt);
            if (filt_b) begin
              state_nx = HOLDOFF;
              hcnt_nx  = H_LEN;
            end else if (tcnt >= T_LAST) begin
              state_nx  = STUCK;
              stuck_set = 1'b1;
            end else begin
              a_drv_nx = 1'b1;
            end
          end
          HOLDOFF: begin
            if (hcnt == 8'd0) state_nx = IDLE;
            else              hcnt_nx  = hcnt - 8'd1;
          end
          STUCK: begin
            if (filt_a && filt_b) state_nx = IDLE;
          end
          default: state_nx = IDLE;
        endcase
      end
      stuck_nx = stuck_set ? 1'b1 : (iClrStuck[i] ? 1'b0 : stuck);
    end

    // Stage p2: registered state, drives and flags
    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        state <= IDLE;
        a_drv <= 1'b0;
        b_drv <= 1'b0;
        busy  <= 1'b0;
        stuck <= 1'b0;
        tcnt  <= '0;
        hcnt  <= 8'd0;
      end else begin
        state <= state_nx;
        a_drv <= a_drv_nx;
        b_drv <= b_drv_nx;
        busy  <= (state_nx != IDLE);
        stuck <= stuck_nx;
        tcnt  <= tcnt_nx;
        hcnt  <= hcnt_nx;
      end
    end

    assign oA_drive_low[i] = a_drv;
    assign oB_drive_low[i] = b_drv;
    assign oStuck[i]       = stuck;
    assign oBusy[i]        = busy;
  end

endmodule
